// File: rtl/bcd_pkg.sv
// Shared BCD constants and conversion helpers for the BCD modulo counter family.
// Conversions work on a fixed 4-digit bus; narrower counters zero-extend into it.
package bcd_pkg;

    localparam int BCD_W          = 4;
    localparam int BCD_MAX        = 9;
    localparam int BCD_MAX_DIGITS = 4;
    localparam int BCD_BUS_W      = BCD_W * BCD_MAX_DIGITS;

    function automatic int unsigned bcd_to_bin(input logic [BCD_BUS_W-1:0] bcd);
        int unsigned v;
        v = 0;
        for (int i = BCD_MAX_DIGITS - 1; i >= 0; i--)
            v = v * 10 + 32'(bcd[i*BCD_W +: BCD_W]);
        return v;
    endfunction

    function automatic logic [BCD_BUS_W-1:0] bin_to_bcd(input int unsigned bin);
        logic [BCD_BUS_W-1:0] r;
        int unsigned          v;
        r = '0;
        v = bin;
        for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
            r[i*BCD_W +: BCD_W] = BCD_W'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_mod_counter_if.sv
// Control/status bundle of one bcd_mod_counter stage; `up` exists only with BCD_CNT_DOWN_EN.
// en/ld/din are sampled on every rising edge with no backpressure: a stage never stalls its driver.
interface bcd_mod_counter_if
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
);
    logic                    en;
    logic                    ld;
    logic [BCD_W*DIGITS-1:0] din;
    logic [BCD_W*DIGITS-1:0] q;
    logic                    tc;
    logic                    ld_err;
`ifdef BCD_CNT_DOWN_EN
    logic                    up;

    modport master (output en, ld, din, up, input  q, tc, ld_err);
    modport slave  (input  en, ld, din, up, output q, tc, ld_err);
`else
    modport master (output en, ld, din, input  q, tc, ld_err);
    modport slave  (input  en, ld, din, output q, tc, ld_err);
`endif

endinterface

// File: rtl/bcd_digit.sv
// One BCD digit: synchronous load/clear, inc or dec on carry-in, carry/borrow out.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             cr,
    input  logic             i_load,
    input  logic             i_clr,
    input  logic [BCD_W-1:0] i_din,
    input  logic             i_ci,
    input  logic             i_dn,
    output logic [BCD_W-1:0] o_q,
    output logic             o_co
);

    logic [BCD_W-1:0] r_q;
    logic             w_edge;

    // Roll-over point for the current direction: 9 going up, 0 going down.
    assign w_edge = i_dn ? (r_q == '0) : (r_q == BCD_W'(BCD_MAX));
    assign o_co   = i_ci & w_edge;
    assign o_q    = r_q;

    always_ff @(posedge clk or negedge cr) begin
        if (!cr) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_din;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_ci) begin
            if (i_dn) r_q <= w_edge ? BCD_W'(BCD_MAX) : r_q - 1'b1;
            else      r_q <= w_edge ? '0 : r_q + 1'b1;
        end
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// Parametrised BCD modulo-N counter with checked load and cascade terminal count.
// Define BCD_CNT_DOWN_EN to add the `up` direction input and down-counting.
module bcd_mod_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS  = 2,
    parameter int MODULUS = 24
)
(
    input  logic             clk,
    input  logic             cr,
    bcd_mod_counter_if.slave bus
);

    localparam int                   W           = BCD_W * DIGITS;
    localparam logic [BCD_BUS_W-1:0] TERM_UP_BCD = bin_to_bcd(MODULUS - 1);

    if (DIGITS < 1 || DIGITS > BCD_MAX_DIGITS || MODULUS < 2 || MODULUS > 10 ** DIGITS) begin : g_bad_param
        $error("bcd_mod_counter: illegal DIGITS=%0d / MODULUS=%0d", DIGITS, MODULUS);
    end

    logic [W-1:0]         w_q;
    logic [W-1:0]         w_term_up;
    logic [W-1:0]         w_ld_val;
    logic [BCD_BUS_W-1:0] w_din_ext;
    logic [DIGITS:0]      w_carry;
    logic                 w_unused_carry;
    logic                 w_dn;
    logic                 w_din_ok;
    logic                 w_at_term;
    logic                 w_cnt;
    logic                 w_wrap;
    logic                 w_digit_ld;
    logic                 w_digit_clr;
    logic                 r_ld_err;

    assign w_term_up = TERM_UP_BCD[W-1:0];

    always_comb begin
        w_din_ext        = '0;
        w_din_ext[W-1:0] = bus.din;
        w_din_ok         = (bcd_to_bin(w_din_ext) < MODULUS);
        for (int i = 0; i < DIGITS; i++)
            if (bus.din[i*BCD_W +: BCD_W] > BCD_W'(BCD_MAX)) w_din_ok = 1'b0;
    end

`ifdef BCD_CNT_DOWN_EN
    assign w_dn = ~bus.up;
`else
    assign w_dn = 1'b0;
`endif

    assign w_at_term = w_dn ? (w_q == '0) : (w_q == w_term_up);
    assign w_cnt     = bus.en & ~bus.ld;
    assign w_wrap    = w_cnt & w_at_term;

    // The modulus wrap bypasses the digit carry chain: up clears, down reloads MODULUS-1.
    assign w_digit_ld  = (bus.ld & w_din_ok) | (w_wrap & w_dn);
    assign w_digit_clr = w_wrap & ~w_dn;
    assign w_ld_val    = bus.ld ? bus.din : w_term_up;
    assign w_carry[0]  = w_cnt & ~w_at_term;
    assign w_unused_carry = w_carry[DIGITS];

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk    (clk),
            .cr     (cr),
            .i_load (w_digit_ld),
            .i_clr  (w_digit_clr),
            .i_din  (w_ld_val[g*BCD_W +: BCD_W]),
            .i_ci   (w_carry[g]),
            .i_dn   (w_dn),
            .o_q    (w_q[g*BCD_W +: BCD_W]),
            .o_co   (w_carry[g+1])
        );
    end

    always_ff @(posedge clk or negedge cr) begin
        if (!cr) r_ld_err <= 1'b0;
        else     r_ld_err <= bus.ld & ~w_din_ok;
    end

    assign bus.q      = w_q;
    assign bus.tc     = w_wrap;
    assign bus.ld_err = r_ld_err;

endmodule
